// File: rtl/exec_cc_stage_pkg.sv
// Shared Y86 execute-stage constants: ALU function codes, condition codes,
// CC register bit positions and the condition evaluation helper.
package exec_cc_stage_pkg;

    // ALU function codes (alu_fun)
    localparam logic [3:0] ALU_ADD = 4'd0;  // B + A
    localparam logic [3:0] ALU_SUB = 4'd1;  // B - A
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;

    // Condition function codes (cond_fun)
    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_LE     = 4'd1;
    localparam logic [3:0] COND_L      = 4'd2;
    localparam logic [3:0] COND_E      = 4'd3;
    localparam logic [3:0] COND_NE     = 4'd4;
    localparam logic [3:0] COND_GE     = 4'd5;
    localparam logic [3:0] COND_G      = 4'd6;

    // CC register layout is {ZF, SF, OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

    function automatic logic alu_fun_legal(input logic [3:0] fun);
        return fun <= ALU_XOR;
    endfunction

    function automatic logic cond_fun_legal(input logic [3:0] fun);
        return fun <= COND_G;
    endfunction

    // Evaluate a condition against a CC value; illegal codes yield 0.
    function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] fun);
        logic zf;
        logic sf;
        logic of;
        logic res;
        zf = cc[CC_ZF];
        sf = cc[CC_SF];
        of = cc[CC_OF];
        case (fun)
            COND_ALWAYS: res = 1'b1;
            COND_LE:     res = (sf ^ of) | zf;
            COND_L:      res = sf ^ of;
            COND_E:      res = zf;
            COND_NE:     res = !zf;
            COND_GE:     res = !(sf ^ of);
            COND_G:      res = !(sf ^ of) & !zf;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu64_core.sv
// Combinational 64-bit Y86 ALU producing the result and the flags it would
// write into CC. Illegal function codes give a zero result and OF=0.
module alu64_core
    import exec_cc_stage_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  fun,
    output logic [63:0] result,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    // Compute the wrap-around result and the signed-overflow flag.
    always_comb begin
        result = '0;
        of     = 1'b0;
        case (fun)
            ALU_ADD: begin
                result = b + a;
                of     = (a[63] == b[63]) && (result[63] != b[63]);
            end
            ALU_SUB: begin
                result = b - a;
                of     = (a[63] != b[63]) && (result[63] != b[63]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: begin
                result = '0;
                of     = 1'b0;
            end
        endcase
    end

    assign zf = (result == 64'd0);
    assign sf = result[63];

endmodule

// File: rtl/exec_cc_stage.sv
// Y86 execute stage: one-entry result register behind a valid/ready
// handshake, the {ZF,SF,OF} condition-code register and condition logic.
module exec_cc_stage
    import exec_cc_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  logic [3:0]  alu_fun,
    input  logic        set_cc,
    input  logic [3:0]  cond_fun,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] val_e,
    output logic        cnd,
    output logic        err,
    output logic [2:0]  cc
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high. The producer keeps valid and data stable until then;
    // ready never depends on valid. The result register may refill on the
    // same edge it is drained, so in_ready is (!out_valid | out_ready).

    logic [63:0] alu_result;
    logic        alu_zf;
    logic        alu_sf;
    logic        alu_of;
    logic        alu_ok;
    logic        cond_ok;
    logic        accept;
    logic        retire;

    alu64_core u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fun    (alu_fun),
        .result (alu_result),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    assign alu_ok   = alu_fun_legal(alu_fun);
    assign cond_ok  = cond_fun_legal(cond_fun);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;

    // Result register, condition outcome and CC update on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            val_e     <= '0;
            cnd       <= 1'b0;
            err       <= 1'b0;
            cc        <= CC_RESET;
        end else if (accept) begin
            out_valid <= 1'b1;
            val_e     <= alu_ok ? alu_result : 64'd0;
            // Condition sees CC as it was before this operation.
            cnd       <= cond_ok ? cond_eval(cc, cond_fun) : 1'b0;
            err       <= !alu_ok || !cond_ok;
            if (set_cc && alu_ok) begin
                cc[CC_ZF] <= alu_zf;
                cc[CC_SF] <= alu_sf;
                cc[CC_OF] <= alu_of;
            end
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

endmodule
